serial_borrow_subtractor: RTL and testbench
===========================================

Name: serial_borrow_subtractor

Overview:
- Bit-serial ripple subtractor computing D = A - B, LSB first, one bit per clock through a single full-subtractor cell.
- The borrow ripples through a register between cycles.
- Inverse companion to the combinational carry-ripple adder; trades area for WIDTH-cycle latency.
- Sits in the datapath lab blocks, driven by a start/done handshake from a controller or testbench.

Parameters:
- WIDTH, 4: operand width in bits; legal range is 2 or more.

Ports:
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; operands sampled when accepted
- A  input  WIDTH  minuend, unsigned (two's complement when the overflow feature is enabled)
- B  input  WIDTH  subtrahend
- D  output  WIDTH  difference register
- bout  output  1  final borrow out (1 means A < B unsigned)
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when D/bout are valid
- ovf  output  1  signed overflow flag (see Optional Feature)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE; D=0, bout=0, busy=0, done=0, ovf=0; internal a_sh, b_sh, borrow and bit counter cleared. Reset wins over start in the same cycle.
- Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE, SHIFT, DONE. The state encoding is a localparam.
- IDLE:
  - start=1 is accepted: latch A into a_sh and B into b_sh, clear borrow, cnt=0, D=0, go to SHIFT.
  - start=0 holds IDLE.
- SHIFT (busy=1), one bit per cycle:
  - d_i = a_sh[0] ^ b_sh[0] ^ borrow
  - borrow_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow)
  - d_i shifts into D from the MSB side (D <= {d_i, D[WIDTH-1:1]}); a_sh and b_sh shift right; cnt increments.
  - When cnt == WIDTH-1: write bout <= borrow_next and go to DONE.
- DONE (busy=0, done=1 for exactly this cycle):
  - Next state is IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); the next state is then SHIFT.
- Latency: start accepted on edge k; SHIFT occupies cycles k+1..k+WIDTH; done is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- start while busy=1 is ignored; operands are not resampled and the result is unaffected.
- A/B changes after acceptance have no effect.
- D, bout and ovf hold their last values from DONE until the next accepted start. On acceptance, bout and ovf clear to 0.
- Arithmetic: D = (A - B) mod 2^WIDTH. bout=1 iff A < B as unsigned values.
  - Equal operands give D=0, bout=0.
  - 0 - max gives D=1, bout=1.
- The counter is ceil(log2(WIDTH)) bits wide and never wraps beyond WIDTH-1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - The MSB signs of A and B are captured at acceptance.
  - In the transition to DONE: ovf <= (A_msb != B_msb) && (d_msb != A_msb), i.e. two's-complement overflow of A - B.
  - ovf is valid and held with D.
- Undefined: ovf is tied to 0, no extra registers are synthesized, and the port remains present so the port list is unchanged.

Decomposition:
- Shared package holds:
  - the state enumeration IDLE/SHIFT/DONE
  - the default WIDTH constant
  - a counter-width helper constant
- One natural sub-module: full_subtractor (a, b, bin -> d, bout), purely combinational. It is the subtract-direction twin of the existing full-adder cell.
- The top level instantiates full_subtractor once, plus the FSM, shift registers and borrow flop.

Test Plan:
- Basic subtract: A=9, B=3, start for 1 cycle -> done high exactly 5 cycles after acceptance; D=6, bout=0; busy high for 4 cycles.
- Borrow: A=3, B=9 -> D=4'hA, bout=1. Also A=0, B=15 -> D=1, bout=1. Also A=15, B=15 -> D=0, bout=0.
- Busy protection: A=12, B=5 accepted, then start=1 with A=1, B=1 during SHIFT -> D=7, bout=0, exactly one done pulse.
- Back-to-back: start asserted in the DONE cycle with A=8, B=2 -> first result observed, second done 5 cycles later with D=6.
- Reset mid-op: assert rst on the 2nd SHIFT cycle -> next cycle D=0, bout=0, busy=0, no done. A following start with A=5, B=4 -> D=1.
- With SERIAL_SUB_OVF_EN: A=4'b1000, B=4'b0001 -> D=4'b0111, ovf=1. A=4'b0011, B=4'b0001 -> ovf=0. Without the macro, ovf stays 0 for both.

Source files
------------

// File: rtl/serial_borrow_subtractor_pkg.sv
// Shared definitions for the bit-serial borrow-ripple subtractor.
// The optional signed-overflow feature is enabled by defining SERIAL_SUB_OVF_EN.
package serial_borrow_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

    // Bit counter only has to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int width);
        if (width <= 2) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_borrow_subtractor_full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow out.
// Purely combinational; the subtract-direction twin of the full-adder cell.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Bit-serial ripple subtractor D = A - B, LSB first, one bit per clock.
// Define SERIAL_SUB_OVF_EN to compute the two's-complement overflow flag ovf.
module serial_borrow_subtractor
    import serial_borrow_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic             bout,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;

    logic               fs_d;
    logic               fs_bout;

`ifdef SERIAL_SUB_OVF_EN
    logic               a_msb_q, a_msb_d;
    logic               b_msb_q, b_msb_d;
    logic               ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (borrow_q),
        .d    (fs_d),
        .bout (fs_bout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            // DONE accepts start exactly like IDLE so operations can run back-to-back.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = SHIFT;
                    a_sh_d   = A;
                    b_sh_d   = B;
                    d_d      = '0;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    bout_d   = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d  = A[WIDTH-1];
                    b_msb_d  = B[WIDTH-1];
                    ovf_d    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                d_d      = {fs_d, d_q[WIDTH-1:1]};
                borrow_d = fs_bout;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    bout_d  = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                    // fs_d is the result MSB on the final bit.
                    ovf_d   = (a_msb_q != b_msb_q) && (fs_d != a_msb_q);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign D    = d_q;
    assign bout = bout_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

`ifdef SERIAL_SUB_OVF_EN
    assign ovf  = ovf_q;
`else
    assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Scoreboard bench for serial_borrow_subtractor: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever done is presented.
module tb_serial_borrow_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] D;
    logic         bout;
    logic         busy;
    logic         done;
    logic         ovf;

    serial_borrow_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .D     (D),
        .bout  (bout),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           a;
        int           b;
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   checks = 0;
    int   busy_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input int a, input int b, input int acc);
        exp_t e;
        int   sa, sb, diff;
        e.a    = a;
        e.b    = b;
        e.acc  = acc;
        e.d    = W'((a - b) & ((1 << W) - 1));
        e.bout = (a < b);
        sa     = (a >= (1 << (W - 1))) ? a - (1 << W) : a;
        sb     = (b >= (1 << (W - 1))) ? b - (1 << W) : b;
        diff   = sa - sb;
`ifdef SERIAL_SUB_OVF_EN
        e.ovf  = (diff > (1 << (W - 1)) - 1) || (diff < -(1 << (W - 1)));
`else
        e.ovf  = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: one compare set per done pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) busy_run++;
            else if (!done) busy_run = 0;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    miscompares++;
                    $display("FAIL spurious_done: got done=1 expected no pending result (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("D", D, e.d);
                    check("bout", bout, e.bout);
                    check("ovf", ovf, e.ovf);
                    check("latency", cyc, e.acc + W);
                    check("busy_cycles", busy_run, W);
                    $display("op A=%0d B=%0d -> D=%0h bout=%0b ovf=%0b (expect D=%0h bout=%0b ovf=%0b)",
                             e.a, e.b, D, bout, ovf, e.d, e.bout, e.ovf);
                end
                busy_run = 0;
            end
        end
    end

    // Called just after a negedge with the DUT in IDLE or DONE.
    task automatic op(input int a, input int b);
        A     = W'(a);
        B     = W'(b);
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(model(a, b, cyc));
        vectors++;
        start = 1'b0;
        A     = W'($urandom);
        B     = W'($urandom);
    endtask

    // Returns at the negedge where done is high; optionally pokes start while busy.
    task automatic wait_done(input bit noise);
        bit seen = 1'b0;
        for (int n = 0; n < 4 * W; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (noise) begin
                start = 1'($urandom);
                A     = W'($urandom);
                B     = W'($urandom);
            end
        end
        start = 1'b0;
        check("done_timeout", seen, 1'b1);
    endtask

    task automatic gap();
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        check("rst_D", D, 0);
        check("rst_bout", bout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        // Reset wins over start.
        start = 1'b1;
        @(negedge clk);
        check("rst_over_start_busy", busy, 0);
        start = 1'b0;
        rst   = 1'b0;
        gap();

        op(9, 3);   wait_done(0); gap();
        op(3, 9);   wait_done(0); gap();
        op(0, 15);  wait_done(0); gap();
        op(15, 15); wait_done(0); gap();

        // Start pulses during SHIFT must be ignored.
        op(12, 5);
        @(negedge clk);
        start = 1'b1; A = 4'd1; B = 4'd1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(0); gap();

        // Back-to-back: new start in the DONE cycle.
        op(7, 9);   wait_done(0);
        op(8, 2);   wait_done(0); gap();

        // Reset on the second SHIFT cycle aborts the operation.
        op(6, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_D", D, 0);
        check("abort_bout", bout, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        gap();
        op(5, 4);   wait_done(0); gap();

        op(8, 1);   wait_done(0); gap();
        op(3, 1);   wait_done(0); gap();

        for (int i = 0; i < 60; i++) begin
            op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)));
            wait_done(1'($urandom));
            if ($urandom_range(0, 1) == 1) gap();
        end

        repeat (W + 3) @(negedge clk);
        check("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
